fft_bitrev_reorder: RTL and testbench

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_bitrev_reorder.sv | 99 +++++++++
 tb/tb_fft_bitrev_reorder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the R22SDF FFT output.
// Ping-pong banks: one frame is written in stream order while the previous one is read out.

package R22SdfDefines;
  localparam int DW = 16;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } Cplx_t;
endpackage

module fft_bitrev_reorder #(
  parameter int STG = 3,
  parameter int DW  = R22SdfDefines::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  R22SdfDefines::Cplx_t in,
  input  logic                 sync_in,
  output R22SdfDefines::Cplx_t out,
  output logic                 out_valid,
  output logic                 sync_out
);

  localparam int N  = 4 ** STG;
  localparam int AW = 2 * STG;

  logic [2*DW-1:0] mem [2*N];

  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;
  logic          wbank;
  logic          rbank;
  logic          ract;

  logic [AW-1:0] idx_p0;
  logic [AW-1:0] waddr_p0;
  logic          last_p0;

  R22SdfDefines::Cplx_t rd_p1;
  logic                 vld_p1;
  logic                 sync_p1;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Stage 0: stream position and bit-reversed write address
  always_comb begin
    idx_p0   = sync_in ? '0 : wcnt;
    waddr_p0 = bitrev(idx_p0);
    last_p0  = &idx_p0;
  end

  always_ff @(posedge clk) begin
    if (en && !rst) mem[{wbank, waddr_p0}] <= in;
  end

  // Stage 1: registered memory read and output flags
  always_ff @(posedge clk) begin
    if (rst) rd_p1 <= '0;
    else if (en && ract) rd_p1 <= mem[{rbank, rcnt}];
  end

  // A completed frame hands its bank to the reader; this overrides the end-of-readout clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      rcnt    <= '0;
      wbank   <= 1'b0;
      rbank   <= 1'b1;
      ract    <= 1'b0;
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
    end else if (en) begin
      wcnt    <= idx_p0 + 1'b1;
      vld_p1  <= ract;
      sync_p1 <= ract && (rcnt == '0);
      if (ract) begin
        rcnt <= rcnt + 1'b1;
        if (&rcnt) ract <= 1'b0;
      end
      if (last_p0) begin
        wbank <= ~wbank;
        rbank <= wbank;
        rcnt  <= '0;
        ract  <= 1'b1;
      end
    end
  end

  assign out       = rd_p1;
  assign out_valid = vld_p1;
  assign sync_out  = sync_p1;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frame-queue reference model checked every cycle,
// plus literal expectations at known cycles (N=64 instance and an N=4 instance).

module tb_fft_bitrev_reorder;

  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, sync_in;
  R22SdfDefines::Cplx_t din, dout;
  logic out_valid, sync_out;

  logic en2, sync2;
  R22SdfDefines::Cplx_t din2, dout2;
  logic vld2, sync_o2;

  fft_bitrev_reorder #(.STG(3)) dut (
    .clk(clk), .rst(rst), .en(en), .in(din), .sync_in(sync_in),
    .out(dout), .out_valid(out_valid), .sync_out(sync_out)
  );

  fft_bitrev_reorder #(.STG(1)) dut4 (
    .clk(clk), .rst(rst), .en(en2), .in(din2), .sync_in(sync2),
    .out(dout2), .out_valid(vld2), .sync_out(sync_o2)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int brev(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r |= 1 << (w - 1 - i);
    return r;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference model: frames collected by natural index, emitted one entry per en-cycle
  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    bit                 first;
  } ent_t;

  ent_t q[$];
  logic signed [15:0] fre [N];
  logic signed [15:0] fim [N];
  int mpos;
  logic signed [15:0] m_re, m_im;
  bit m_vld, m_sync;

  always @(posedge clk) begin : model
    ent_t e;
    int p;
    if (rst) begin
      q.delete();
      m_re = 0; m_im = 0; m_vld = 0; m_sync = 0; mpos = 0;
    end else if (en) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        m_re = e.re; m_im = e.im; m_vld = 1; m_sync = e.first;
      end else begin
        m_vld = 0; m_sync = 0;
      end
      p = sync_in ? 0 : mpos;
      fre[brev(p, 6)] = din.re;
      fim[brev(p, 6)] = din.im;
      if (p == N - 1) begin
        for (int k = 0; k < N; k++) begin
          e.re = fre[k]; e.im = fim[k]; e.first = (k == 0);
          q.push_back(e);
        end
      end
      mpos = (p + 1) % N;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_valid", out_valid, m_vld);
      chk("model_sync", sync_out, m_sync);
      chk("model_re", dout.re, m_re);
      chk("model_im", dout.im, m_im);
    end
  end

  initial begin
    int p;
    int guard;
    int ecnt;
    rst = 1; en = 1; sync_in = 0; din = '0;
    en2 = 1; sync2 = 0; din2 = '0;
    tick;
    chk_on = 1'b1;
    tick;
    chk("rst_re", dout.re, 0);
    chk("rst_im", dout.im, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sync", sync_out, 0);
    chk("rst4_valid", vld2, 0);
    rst = 0;

    // N=4: a0..a3 in stream order come out as a0,a2,a1,a3
    for (int c = 0; c < 10; c++) begin
      case (c)
        5: begin chk("n4_x0", dout2.re, 10); chk("n4_sync0", sync_o2, 1); chk("n4_vld0", vld2, 1); end
        6: begin chk("n4_x1", dout2.re, 12); chk("n4_sync1", sync_o2, 0); end
        7: chk("n4_x2", dout2.re, 11);
        8: begin chk("n4_x3", dout2.re, 13); chk("n4_x3_im", dout2.im, -13); end
        9: begin chk("n4_next_sync", sync_o2, 1); chk("n4_next_re", dout2.re, 0); chk("n4_next_vld", vld2, 1); end
        default: ;
      endcase
      sync2 = (c == 0);
      din2.re = (c < 4) ? 16'(10 + c) : 16'sd0;
      din2.im = -din2.re;
      tick;
    end
    sync2 = 0; din2 = '0;

    // Frame, restarted frame, three back-to-back frames, then reset mid-readout
    for (int c = 0; c <= 372; c++) begin
      case (c)
        65:  begin chk("a_vld", out_valid, 1); chk("a_sync", sync_out, 1); chk("a_x0_re", dout.re, 0); chk("a_x0_im", dout.im, 0); end
        66:  begin chk("a_x1_re", dout.re, 1); chk("a_x1_im", dout.im, -32); chk("a_x1_sync", sync_out, 0); end
        128: begin chk("a_x63_vld", out_valid, 1); chk("a_x63_re", dout.re, 63); chk("a_x63_im", dout.im, -63); end
        129: chk("a_end_vld", out_valid, 0);
        149: begin chk("c_x0_re", dout.re, 2000); chk("c_x0_sync", sync_out, 1); chk("c_x0_im", dout.im, 0); end
        150: begin chk("c_x1_re", dout.re, 2032); chk("c_x1_im", dout.im, 32); end
        212: begin chk("c_x63_re", dout.re, 2063); chk("c_x63_im", dout.im, 63); end
        213: begin chk("b1_x0_re", dout.re, 3000); chk("b1_sync", sync_out, 1); chk("b1_vld", out_valid, 1); end
        277: begin chk("b2_x0_re", dout.re, 3064); chk("b2_sync", sync_out, 1); end
        371: begin chk("b3_x30_re", dout.re, 3158); chk("b3_x30_im", dout.im, 30); chk("b3_x30_vld", out_valid, 1); end
        372: begin chk("e_re", dout.re, 0); chk("e_im", dout.im, 0); chk("e_vld", out_valid, 0); chk("e_sync", sync_out, 0); end
        default: ;
      endcase
      if (c == 372) break;
      sync_in = 0; rst = 0;
      if (c < 64) begin
        sync_in = (c == 0); din.re = 16'(brev(c, 6)); din.im = 16'(-c);
      end else if (c < 84) begin
        sync_in = (c == 64); din.re = 16'(1000 + c - 64); din.im = 16'sd0;
      end else if (c < 148) begin
        sync_in = (c == 84); din.re = 16'(2000 + c - 84); din.im = 16'(c - 84);
      end else if (c < 340) begin
        sync_in = ((c - 148) % 64 == 0); din.re = 16'(3000 + c - 148); din.im = 16'((c - 148) % 64);
      end else begin
        din = '0; rst = (c == 371);
      end
      tick;
    end
    rst = 0; sync_in = 0; din = '0;

    // Partial frame after reset, then a frame with en toggling, discarded partial
    for (int c = 0; c < 20; c++) begin
      din.re = 16'(500 + c);
      tick;
    end
    p = 0; guard = 0;
    while (p < N && guard < 1000) begin
      en = 1'($urandom_range(0, 1));
      sync_in = (p == 0);
      din.re = 16'(brev(p, 6)); din.im = 16'(-p);
      tick;
      if (en) p++;
      guard++;
    end
    chk("d_frame_fed", p, N);
    sync_in = 0; din = '0;
    ecnt = 0; guard = 0;
    while (ecnt < N + 4 && guard < 1000) begin
      en = 1'($urandom_range(0, 1));
      tick;
      if (en) ecnt++;
      guard++;
    end
    chk("d_readout_done", ecnt, N + 4);
    en = 1;
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
